// File: rtl/mips_dbus_responder_if.sv
// rtl/mips_dbus_responder_if.sv - core data bus plus host drain port of the dbus responder
interface mips_dbus_responder_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output memwrite, memaddr, memwritedata, out_ready,
        input  memreaddata, out_valid, out_data
    );

    modport slave (
        input  memwrite, memaddr, memwritedata, out_ready,
        output memreaddata, out_valid, out_data
    );
endinterface

// File: rtl/mips_dbus_responder.sv
// rtl/mips_dbus_responder.sv - data RAM, timer, output FIFO and status on the core data bus
// Optional compare/irq feature enabled by defining TIMER_IRQ_EN.
module mips_dbus_responder #(
    parameter int RAM_AW  = 6,
    parameter int FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_dbus_responder_if.slave bus
`ifdef TIMER_IRQ_EN
    ,
    output logic                 irq
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [31:0]        ram [0:(1 << RAM_AW) - 1];
    logic [31:0]        fifo_mem [0:DEPTH - 1];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count;
    logic [31:0]        timer, timer_nxt;
    logic               ovf;

    logic               is_io;
    logic [15:0]        ioff;
    logic [RAM_AW-1:0]  ram_idx;
    logic               wr_ram, wr_timer, wr_fifo, wr_stat;
    logic               full, push, pop, do_push;
    logic [6:0]         cnt7;
    logic               unused_addr;

    assign is_io       = (bus.memaddr[31:16] == 16'hFFFF);
    assign ioff        = bus.memaddr[15:0];
    assign ram_idx     = bus.memaddr[RAM_AW+1:2];
    assign unused_addr = ^bus.memaddr[1:0];

    assign wr_ram   = bus.memwrite & ~is_io;
    assign wr_timer = bus.memwrite & is_io & (ioff == 16'h0000);
    assign wr_fifo  = bus.memwrite & is_io & (ioff == 16'h0004);
    assign wr_stat  = bus.memwrite & is_io & (ioff == 16'h0008);

    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign push    = wr_fifo;
    assign pop     = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign cnt7    = 7'(count);

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : 32'h0;

    assign timer_nxt = wr_timer ? bus.memwritedata : timer + 32'd1;

`ifdef TIMER_IRQ_EN
    logic [31:0] cmp;
    logic        wr_cmp;

    assign wr_cmp = bus.memwrite & is_io & (ioff == 16'h000C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp <= 32'h0;
            irq <= 1'b0;
        end else if (wr_cmp) begin
            cmp <= bus.memwritedata;
            irq <= 1'b0;
        end else if (timer_nxt == cmp) begin
            irq <= 1'b1;
        end
    end
`endif

    always_comb begin
        bus.memreaddata = 32'h0;
        if (is_io) begin
            case (ioff)
                16'h0000: bus.memreaddata = timer;
                16'h0004: bus.memreaddata = {24'h0, cnt7, full};
                16'h0008: bus.memreaddata = {31'h0, ovf};
`ifdef TIMER_IRQ_EN
                16'h000C: bus.memreaddata = cmp;
`endif
                default:  bus.memreaddata = 32'h0;
            endcase
        end else begin
            bus.memreaddata = ram[ram_idx];
        end
    end

    // Storage arrays carry no reset so RAM contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= bus.memwritedata;
        end
        if (do_push) begin
            fifo_mem[wr_ptr] <= bus.memwritedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer  <= 32'h0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            timer <= timer_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
            // Set takes priority over clear.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_stat) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule
